// File: rtl/ucpu_pkg.sv
// Shared definitions for the micro-CPU: opcodes, control FSM states and the
// accumulator-source / ALU-operation encodings used by the datapath blocks.
package ucpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'b00,
    ST_EXECUTE = 2'b01,
    ST_HALT    = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    SEL_ALU = 2'b00,
    SEL_REG = 2'b10,
    SEL_IMM = 2'b11
  } selacc_e;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } aluop_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LDR = 4'h2;
  localparam logic [3:0] OP_STR = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_HLT = 4'hF;

endpackage

// File: rtl/control_unit_if.sv
// Bus between the control unit and its program memory / datapath neighbours.
interface control_unit_if #(
  parameter int PC_WIDTH = 8
);
  logic                run;
  logic [7:0]          instr;
  logic                zero;
  logic [PC_WIDTH-1:0] pc;
  logic                loadacc;
  logic [1:0]          selacc;
  logic [3:0]          imm;
  logic [1:0]          aluop;
  logic                loadreg;
  logic                halted;

  // Control unit side: consumes run/instr/zero, drives pc and strobes.
  modport master (
    input  run, instr, zero,
    output pc, loadacc, selacc, imm, aluop, loadreg, halted
  );

  // Environment side: program memory, accumulator and register file.
  modport slave (
    output run, instr, zero,
    input  pc, loadacc, selacc, imm, aluop, loadreg, halted
  );
endinterface

// File: rtl/control_unit_insn_decode.sv
// Combinational instruction decoder: turns FSM state and opcode into the
// datapath strobes and a jump-taken flag. All outputs idle outside EXECUTE.
module insn_decode
  import ucpu_pkg::*;
(
  input  state_e     state_i,
  input  logic [3:0] opcode_i,
  input  logic       zero_i,
  output logic       loadacc_o,
  output logic       loadreg_o,
  output selacc_e    selacc_o,
  output aluop_e     aluop_o,
  output logic       jump_o,
  output logic       halt_o
);

  // Decode the opcode only while executing; unlisted opcodes act as NOP.
  always_comb begin
    loadacc_o = 1'b0;
    loadreg_o = 1'b0;
    selacc_o  = SEL_ALU;
    aluop_o   = ALU_ADD;
    jump_o    = 1'b0;
    halt_o    = 1'b0;
    if (state_i == ST_EXECUTE) begin
      case (opcode_i)
        OP_LDI: begin
          loadacc_o = 1'b1;
          selacc_o  = SEL_IMM;
        end
        OP_LDR: begin
          loadacc_o = 1'b1;
          selacc_o  = SEL_REG;
        end
        OP_STR: loadreg_o = 1'b1;
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          loadacc_o = 1'b1;
          selacc_o  = SEL_ALU;
          aluop_o   = aluop_e'(opcode_i[1:0]);
        end
        OP_JMP: jump_o = 1'b1;
        OP_JZ:  jump_o = zero_i;
        OP_HLT: halt_o = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_unit.sv
// Two-cycle fetch/execute sequencer for the micro-CPU. Owns pc, ir and the
// FSM; strobes come from the combinational decoder so a reset drops them
// immediately.
module control_unit
  import ucpu_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic           clk,
  input  logic           clr,
  control_unit_if.master bus
);

  state_e              state_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [7:0]          ir_q;

  logic    loadacc_d;
  logic    loadreg_d;
  selacc_e selacc_d;
  aluop_e  aluop_d;
  logic    jump_d;
  logic    halt_d;

  insn_decode u_decode (
    .state_i   (state_q),
    .opcode_i  (ir_q[7:4]),
    .zero_i    (bus.zero),
    .loadacc_o (loadacc_d),
    .loadreg_o (loadreg_d),
    .selacc_o  (selacc_d),
    .aluop_o   (aluop_d),
    .jump_o    (jump_d),
    .halt_o    (halt_d)
  );

  // Sequencer: fetch latches ir and bumps pc; execute applies jumps and
  // either returns to fetch or parks in HALT until the next reset.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      ir_q    <= 8'h00;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (bus.run) begin
            ir_q    <= bus.instr;
            pc_q    <= pc_q + PC_WIDTH'(1);
            state_q <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          // Jumps stay inside the page of the already-incremented pc.
          if (jump_d) pc_q <= {pc_q[PC_WIDTH-1:4], ir_q[3:0]};
          state_q <= halt_d ? ST_HALT : ST_FETCH;
        end
        ST_HALT: ;
        default: state_q <= ST_FETCH;
      endcase
    end
  end

  assign bus.pc      = pc_q;
  assign bus.imm     = ir_q[3:0];
  assign bus.loadacc = loadacc_d;
  assign bus.loadreg = loadreg_d;
  assign bus.selacc  = selacc_d;
  assign bus.aluop   = aluop_d;
  assign bus.halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: program memory model plus hand-computed
// expectations for decode, sequencing, jumps, wrap, run gating, halt, reset.
module tb_control_unit;

  logic clk;
  logic clr;
  int   n_cmp;
  int   n_err;
  logic [7:0] mem [256];

  control_unit_if #(.PC_WIDTH(8)) bus ();

  control_unit #(.PC_WIDTH(8)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program memory read port addressed by pc.
  always_comb bus.instr = mem[bus.pc];

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".loadacc"}, 32'(bus.loadacc), 32'd0);
    chk({tag, ".loadreg"}, 32'(bus.loadreg), 32'd0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    clear_mem();
    mem[0] = 8'h15; mem[1] = 8'h32; mem[2] = 8'h43;
    mem[3] = 8'h27; mem[4] = 8'h51; mem[5] = 8'h62;
    mem[6] = 8'h7E; mem[7] = 8'hA3;
    mem[8'h12] = 8'h8A;
    mem[8'h1A] = 8'h93;
    mem[8'h1B] = 8'h93;
    clr = 1'b1;
    bus.run  = 1'b0;
    bus.zero = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst.pc", 32'(bus.pc), 32'h00);
    chk("rst.halted", 32'(bus.halted), 32'd0);
    chk_idle("rst");
    chk("rst.selacc", 32'(bus.selacc), 32'd0);
    chk("rst.aluop", 32'(bus.aluop), 32'd0);
    chk("rst.imm", 32'(bus.imm), 32'd0);
    bus.run = 1'b1;
    clr = 1'b0;

    // Program 0x15,0x32,0x43 then LDR/SUB/AND/OR/undefined
    tick();
    chk("ldi.loadacc", 32'(bus.loadacc), 32'd1);
    chk("ldi.selacc", 32'(bus.selacc), 32'b11);
    chk("ldi.imm", 32'(bus.imm), 32'd5);
    chk("ldi.pc", 32'(bus.pc), 32'h01);
    tick();
    chk_idle("fetch1");
    chk("fetch1.pc", 32'(bus.pc), 32'h01);
    tick();
    chk("str.loadreg", 32'(bus.loadreg), 32'd1);
    chk("str.loadacc", 32'(bus.loadacc), 32'd0);
    chk("str.imm", 32'(bus.imm), 32'd2);
    tick(); tick();
    chk("add.loadacc", 32'(bus.loadacc), 32'd1);
    chk("add.selacc", 32'(bus.selacc), 32'b00);
    chk("add.aluop", 32'(bus.aluop), 32'b00);
    chk("add.pc", 32'(bus.pc), 32'h03);
    tick(); tick();
    chk("ldr.selacc", 32'(bus.selacc), 32'b10);
    chk("ldr.imm", 32'(bus.imm), 32'd7);
    tick(); tick();
    chk("sub.aluop", 32'(bus.aluop), 32'b01);
    tick(); tick();
    chk("and.aluop", 32'(bus.aluop), 32'b10);
    tick(); tick();
    chk("or.aluop", 32'(bus.aluop), 32'b11);
    chk("or.loadacc", 32'(bus.loadacc), 32'd1);
    tick(); tick();
    chk_idle("opA");
    chk("opA.selacc", 32'(bus.selacc), 32'd0);
    chk("opA.imm", 32'(bus.imm), 32'd3);
    tick();
    chk("seq.pc8", 32'(bus.pc), 32'h08);

    // JMP 0x8A fetched at 0x12
    repeat (20) tick();
    chk("jmp.pre", 32'(bus.pc), 32'h12);
    tick();
    chk("jmp.exec_pc", 32'(bus.pc), 32'h13);
    chk_idle("jmp.exec");
    tick();
    chk("jmp.target", 32'(bus.pc), 32'h1A);

    // JZ with zero=0, then zero=1
    tick(); tick();
    chk("jz0.pc", 32'(bus.pc), 32'h1B);
    bus.zero = 1'b1;
    tick();
    chk("jz1.exec_pc", 32'(bus.pc), 32'h1C);
    tick();
    chk("jz1.target", 32'(bus.pc), 32'h13);
    bus.zero = 1'b0;

    // Increment wrap 0xFF -> 0x00
    repeat (472) tick();
    chk("wrap.pre", 32'(bus.pc), 32'hFF);
    tick();
    chk("wrap.pc", 32'(bus.pc), 32'h00);
    tick();

    // JMP fetched at 0xFF lands in page 0
    clear_mem();
    mem[8'hFF] = 8'h85;
    repeat (510) tick();
    chk("wjmp.pre", 32'(bus.pc), 32'hFF);
    tick();
    chk("wjmp.exec_pc", 32'(bus.pc), 32'h00);
    tick();
    chk("wjmp.target", 32'(bus.pc), 32'h05);

    // run=0 in FETCH freezes everything
    mem[5] = 8'h17;
    mem[6] = 8'h8C;
    bus.run = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold.pc", 32'(bus.pc), 32'h05);
      chk_idle("hold");
    end
    bus.run = 1'b1;
    tick();
    chk("resume.loadacc", 32'(bus.loadacc), 32'd1);
    chk("resume.imm", 32'(bus.imm), 32'd7);
    bus.run = 1'b0;
    chk("rundrop.loadacc", 32'(bus.loadacc), 32'd1);
    tick();
    chk("rundrop.pc", 32'(bus.pc), 32'h06);
    chk_idle("rundrop.fetch");
    tick();
    chk("rundrop.frozen", 32'(bus.pc), 32'h06);

    // run dropped during a JMP execute still completes the jump
    bus.run = 1'b1;
    tick();
    chk("jmpdrop.exec_pc", 32'(bus.pc), 32'h07);
    bus.run = 1'b0;
    tick();
    chk("jmpdrop.target", 32'(bus.pc), 32'h0C);

    // HLT
    mem[8'h0C] = 8'hF0;
    bus.run = 1'b1;
    tick();
    chk("hlt.exec_halted", 32'(bus.halted), 32'd0);
    chk("hlt.exec_pc", 32'(bus.pc), 32'h0D);
    tick();
    chk("hlt.halted", 32'(bus.halted), 32'd1);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("halt.pc", 32'(bus.pc), 32'h0D);
      chk("halt.halted", 32'(bus.halted), 32'd1);
      chk_idle("halt");
    end
    clr = 1'b1;
    #1;
    chk("hltclr.pc", 32'(bus.pc), 32'h00);
    chk("hltclr.halted", 32'(bus.halted), 32'd0);
    clr = 1'b0;

    // Async reset in the middle of an LDI execute
    mem[0] = 8'h15;
    tick();
    chk("aclr.pre_loadacc", 32'(bus.loadacc), 32'd1);
    chk("aclr.pre_pc", 32'(bus.pc), 32'h01);
    clr = 1'b1;
    #1;
    chk("aclr.loadacc", 32'(bus.loadacc), 32'd0);
    chk("aclr.pc", 32'(bus.pc), 32'h00);
    chk("aclr.imm", 32'(bus.imm), 32'd0);
    #1;
    clr = 1'b0;
    tick();
    chk("postclr.loadacc", 32'(bus.loadacc), 32'd1);
    chk("postclr.pc", 32'(bus.pc), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL: PC_WIDTH, 8, program counter width in bits (minimum 4).
REQ-002 SHALL: clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL: clr  input  1  reset, asynchronous, active-high.
REQ-004 SHALL: run  input  1  fetch enable; 0 holds the unit in FETCH.
REQ-005 SHALL: instr  input  8  instruction word from program memory at pc; opcode = instr[7:4], operand = instr[3:0].
REQ-006 SHALL: zero  input  1  accumulator-equals-zero flag, valid in EXECUTE.
REQ-007 SHALL: pc  output  PC_WIDTH  program counter, addresses program memory.
REQ-008 SHALL: loadacc  output  1  accumulator load strobe.
REQ-009 SHALL: selacc  output  2  accumulator source: 00 ALU, 10 register, 11 immediate.
REQ-010 SHALL: imm  output  4  immediate / register index, equal to ir[3:0].
REQ-011 SHALL: aluop  output  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-012 SHALL: loadreg  output  1  register-file write strobe; data is accumulator, address is imm.
REQ-013 SHALL: halted  output  1  high while in HALT.

Function
REQ-014 SHALL: FSM states FETCH, EXECUTE, HALT; every instruction takes exactly 2 cycles.
REQ-015 SHALL: FETCH with run=1: ir <= instr, pc <= pc+1, next EXECUTE; with run=0: ir, pc, state held.
REQ-016 SHALL: EXECUTE always completes regardless of run, then returns to FETCH (or HALT).
REQ-017 SHALL: strobes loadacc/loadreg asserted only in EXECUTE, one cycle, combinationally decoded from state and ir; selacc/aluop = 00 when loadacc=0.
REQ-018 SHALL: decode: 0x0 NOP; 0x1 LDI (loadacc, selacc=11); 0x2 LDR (loadacc, selacc=10); 0x3 STR (loadreg); 0x4-0x7 ALU (loadacc, selacc=00, aluop=opcode[1:0]); 0x8 JMP; 0x9 JZ; 0xF HLT; 0xA-0xE executed as NOP.
REQ-019 SHALL: JMP in EXECUTE: pc <= {pc[PC_WIDTH-1:4], operand} (page-relative, using already-incremented pc).
REQ-020 SHALL: JZ: same target as JMP when zero=1 sampled in EXECUTE; else pc unchanged.
REQ-021 SHALL: HLT: EXECUTE -> HALT; HALT holds pc, ir, all strobes 0, halted=1, exits only by reset.
REQ-022 SHALL: pc increment wraps modulo 2^PC_WIDTH (all-ones -> 0); jump never carries into upper page bits.
REQ-023 SHALL: no output strobe in FETCH or HALT.

Reset
REQ-024 SHALL: clr=1 asynchronously forces state=FETCH, pc=0, ir=0x00, halted=0, loadacc=0, loadreg=0, selacc=00, aluop=00, imm=0.
REQ-025 SHALL: reset asserted mid-EXECUTE drops strobes immediately; the interrupted instruction has no effect on pc.
REQ-026 SHALL: first FETCH occurs on first rising edge after clr deasserts with run=1.

Structure
REQ-027 SHALL: shared package ucpu_pkg holds opcode constants, state enumeration, selacc and aluop encodings, for use by accumulator/ALU/register-file neighbours.
REQ-028 SHALL: one combinational sub-module insn_decode (state, ir, zero -> strobes, selacc, aluop, jump-taken); sequencing, pc, ir live in control_unit.

Verification
REQ-029 SHALL: reset then run=1, program {0x15, 0x32, 0x43} -> cycle 2 loadacc=1 selacc=11 imm=5; cycle 4 loadreg=1 imm=2; cycle 6 loadacc=1 selacc=00 aluop=00; pc 0->1->...->3.
REQ-030 SHALL: JMP 0x8A at pc=0x12 -> pc=0x1A after EXECUTE; JZ 0x93 with zero=0 -> pc advances by 1 only; with zero=1 -> pc low nibble=3.
REQ-031 SHALL: pc=0xFF, fetch NOP -> pc=0x00 next; JMP at pc=0xFF -> pc=0x0 page with operand.
REQ-032 SHALL: run=0 during FETCH for 5 cycles -> pc and state frozen, no strobes; run dropped during EXECUTE -> instruction still completes.
REQ-033 SHALL: HLT 0xF0 -> halted=1 from following cycle, pc frozen for 10 cycles despite run=1; clr pulse -> pc=0, halted=0.
REQ-034 SHALL: clr asserted asynchronously mid-EXECUTE of LDI -> loadacc falls before next edge, pc=0.
